// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the multi-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned TMO_W      = 8;

  // Next index in a ring of n masters.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Rotating-priority selector: first set request at or after the start index wins.
module arb_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!o_valid && i_req[j] && (((32'(i_start) + k) % N) == j)) begin
          o_valid    = 1'b1;
          o_grant[j] = 1'b1;
          o_idx      = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-master arbiter serialising requests onto one slave bus with wait states and timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_MASTERS-1:0]        HTRANS,
  input  logic [NUM_MASTERS*ADDR_W-1:0] HADDR,
  input  logic [NUM_MASTERS-1:0]        HWRITE,
  input  logic [NUM_MASTERS*DATA_W-1:0] HWDATA,
  output logic [NUM_MASTERS-1:0]        HREADY,
  output logic [NUM_MASTERS-1:0]        HRESP,
  output logic [DATA_W-1:0]             HRDATA,
  output logic                          stall,
  output logic                          PSEL,
  output logic [ADDR_W-1:0]             PADDR,
  output logic                          PWRITE,
  output logic [DATA_W-1:0]             PDATA,
  input  logic                          PREADY,
  input  logic [DATA_W-1:0]             PRDATA
);

  localparam int unsigned IW = $clog2(NUM_MASTERS);

  state_e                   r_state;
  state_e                   w_next;
  logic [IW-1:0]            w_start;
  logic [NUM_MASTERS-1:0]   w_win_oh;
  logic [IW-1:0]            w_win_idx;
  logic                     w_win_valid;
  logic [ADDR_W-1:0]        w_addr;
  logic                     w_wr;
  logic [DATA_W-1:0]        w_wdata;
  logic                     w_load;
  logic                     w_done;
  logic                     w_tmo;
  logic [TMO_W-1:0]         r_wait;
  logic [NUM_MASTERS-1:0]   r_grant_oh;
  logic [NUM_MASTERS-1:0]   r_hready;
  logic [NUM_MASTERS-1:0]   r_hresp;
  logic [DATA_W-1:0]        r_hrdata;
  logic                     r_psel;
  logic [ADDR_W-1:0]        r_paddr;
  logic                     r_pwrite;
  logic [DATA_W-1:0]        r_pdata;

  arb_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .i_req   (HTRANS),
    .i_start (w_start),
    .o_grant (w_win_oh),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_grant;

  // Pointer moves past the served master only once its response is issued.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      if (w_load)
        r_grant <= w_win_idx;
      if (r_state == RESP)
        r_ptr <= IW'(wrap_inc(32'(r_grant), NUM_MASTERS));
    end
  end

  assign w_start = r_ptr;
`else
  assign w_start = '0;
`endif

  // Winner's request payload.
  always_comb begin
    w_addr  = '0;
    w_wr    = 1'b0;
    w_wdata = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (w_win_idx == IW'(i)) begin
        w_addr  = HADDR[i*ADDR_W +: ADDR_W];
        w_wr    = HWRITE[i];
        w_wdata = HWDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_win_valid) w_next = ACCESS;
      ACCESS:  if (w_done || w_tmo) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // PREADY takes precedence over a timeout landing in the same cycle.
  always_comb begin
    w_load = 1'b0;
    w_done = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      IDLE:    w_load = w_win_valid;
      ACCESS: begin
        w_done = PREADY;
        w_tmo  = !PREADY && (r_wait == TMO_W'(TIMEOUT - 1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wait     <= '0;
      r_grant_oh <= '0;
      r_hready   <= '0;
      r_hresp    <= '0;
      r_hrdata   <= '0;
      r_psel     <= 1'b0;
      r_paddr    <= '0;
      r_pwrite   <= 1'b0;
      r_pdata    <= '0;
    end else begin
      r_hready <= '0;
      r_hresp  <= '0;
      if (w_load) begin
        r_paddr    <= w_addr;
        r_pwrite   <= w_wr;
        r_pdata    <= w_wdata;
        r_psel     <= 1'b1;
        r_grant_oh <= w_win_oh;
        r_wait     <= '0;
      end
      if (w_done) begin
        r_hrdata <= PRDATA;
        r_psel   <= 1'b0;
        r_hready <= r_grant_oh;
      end else if (w_tmo) begin
        r_psel   <= 1'b0;
        r_hready <= r_grant_oh;
        r_hresp  <= r_grant_oh;
      end else if (r_state == ACCESS) begin
        r_wait <= r_wait + TMO_W'(1);
      end
    end
  end

  assign HREADY = r_hready;
  assign HRESP  = r_hresp;
  assign HRDATA = r_hrdata;
  assign PSEL   = r_psel;
  assign PADDR  = r_paddr;
  assign PWRITE = r_pwrite;
  assign PDATA  = r_pdata;
  assign stall  = |(HTRANS & ~r_hready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (two masters, TIMEOUT=15).
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned NM  = 2;
  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;
  localparam int unsigned TMO = 15;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [NM-1:0]    HTRANS;
  logic [NM*AW-1:0] HADDR;
  logic [NM-1:0]    HWRITE;
  logic [NM*DW-1:0] HWDATA;
  logic [NM-1:0]    HREADY;
  logic [NM-1:0]    HRESP;
  logic [DW-1:0]    HRDATA;
  logic             stall;
  logic             PSEL;
  logic [AW-1:0]    PADDR;
  logic             PWRITE;
  logic [DW-1:0]    PDATA;
  logic             PREADY;
  logic [DW-1:0]    PRDATA;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .stall(stall),
    .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE), .PDATA(PDATA), .PREADY(PREADY),
    .PRDATA(PRDATA)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic wait_hready(output logic [NM-1:0] got, output int n);
    got = '0;
    n   = 0;
    while (got == '0 && n < 100) begin
      @(negedge CLK);
      n++;
      got = HREADY;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; HTRANS = '0; HADDR = '0; HWRITE = '0; HWDATA = '0;
    PREADY = 1'b0; PRDATA = '0;
    repeat (2) @(negedge CLK);
    checks++; if (PSEL !== 1'b0) begin failures++; $display("FAIL reset_psel got=%0h exp=0", PSEL); end
    checks++; if (PADDR !== '0) begin failures++; $display("FAIL reset_paddr got=%0h exp=0", PADDR); end
    checks++; if ({PWRITE, PDATA} !== '0) begin failures++; $display("FAIL reset_pwrite_pdata got=%0h/%0h exp=0", PWRITE, PDATA); end
    checks++; if (HRDATA !== '0) begin failures++; $display("FAIL reset_hrdata got=%0h exp=0", HRDATA); end
    checks++; if ({HREADY, HRESP} !== '0) begin failures++; $display("FAIL reset_hready_hresp got=%0h/%0h exp=0", HREADY, HRESP); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall); end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single_read();
    HADDR[AW +: AW] = 64'h1000; HWRITE = '0; PREADY = 1'b1; PRDATA = 64'hDEADBEEF;
    HTRANS = 2'b10;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rd_stall_req got=%0h exp=1", stall); end
    @(negedge CLK);
    checks++; if (PSEL !== 1'b1) begin failures++; $display("FAIL rd_psel got=%0h exp=1", PSEL); end
    checks++; if (PADDR !== 64'h1000) begin failures++; $display("FAIL rd_paddr got=%0h exp=1000", PADDR); end
    checks++; if (PWRITE !== 1'b0) begin failures++; $display("FAIL rd_pwrite got=%0h exp=0", PWRITE); end
    checks++; if ({HREADY, stall} !== 3'b001) begin failures++; $display("FAIL rd_early_hready_stall got=%0h/%0h exp=0/1", HREADY, stall); end
    @(negedge CLK);
    checks++; if (HREADY !== 2'b10) begin failures++; $display("FAIL rd_hready got=%0h exp=2", HREADY); end
    checks++; if (HRESP !== 2'b00) begin failures++; $display("FAIL rd_hresp got=%0h exp=0", HRESP); end
    checks++; if (HRDATA !== 64'hDEADBEEF) begin failures++; $display("FAIL rd_hrdata got=%0h exp=deadbeef", HRDATA); end
    checks++; if ({PSEL, stall} !== 2'b00) begin failures++; $display("FAIL rd_resp_psel_stall got=%0h/%0h exp=0/0", PSEL, stall); end
    HTRANS = '0;
    @(negedge CLK);
    checks++; if (HREADY !== 2'b00) begin failures++; $display("FAIL rd_hready_pulse_width got=%0h exp=0", HREADY); end
    repeat (2) @(negedge CLK);
    checks++; if ({PSEL, HREADY} !== 3'b000) begin failures++; $display("FAIL idle_pready_ignored got=%0h/%0h exp=0/0", PSEL, HREADY); end
    PREADY = 1'b0;
  endtask

  task automatic test_timeout(input bit ready_at_limit, input logic [DW-1:0] exp_rdata);
    int cnt;
    logic [NM-1:0] got;
    logic [NM-1:0] resp;
    cnt = 0; got = '0; resp = '0;
    PRDATA = 64'h0BADF00D; PREADY = 1'b0; HADDR[AW +: AW] = 64'h40; HTRANS = 2'b10;
    for (int k = 0; k < 60 && got == '0; k++) begin
      @(negedge CLK);
      if (PSEL) begin
        cnt++;
        if (ready_at_limit && cnt == TMO) PREADY = 1'b1;
      end
      got  = HREADY;
      resp = HRESP;
    end
    HTRANS = '0; PREADY = 1'b0;
    checks++; if (cnt !== TMO) begin failures++; $display("FAIL tmo_psel_cycles ready=%0d got=%0d exp=%0d", ready_at_limit, cnt, TMO); end
    checks++; if (got !== 2'b10) begin failures++; $display("FAIL tmo_hready ready=%0d got=%0h exp=2", ready_at_limit, got); end
    checks++; if (resp !== (ready_at_limit ? 2'b00 : 2'b10)) begin failures++; $display("FAIL tmo_hresp ready=%0d got=%0h exp=%0h", ready_at_limit, resp, ready_at_limit ? 2'b00 : 2'b10); end
    checks++; if (HRDATA !== exp_rdata) begin failures++; $display("FAIL tmo_hrdata ready=%0d got=%0h exp=%0h", ready_at_limit, HRDATA, exp_rdata); end
    @(negedge CLK);
    checks++; if ({HREADY, HRESP} !== 4'b0000) begin failures++; $display("FAIL tmo_pulse_width got=%0h/%0h exp=0/0", HREADY, HRESP); end
  endtask

  task automatic test_write_wait();
    int cnt;
    int bad;
    logic [NM-1:0] got;
    cnt = 0; bad = 0; got = '0;
    HADDR[0 +: AW] = 64'h20; HWDATA[0 +: DW] = 64'h55; HWRITE = 2'b01; PREADY = 1'b0;
    HTRANS = 2'b01;
    for (int k = 0; k < 60 && got == '0; k++) begin
      @(negedge CLK);
      if (PSEL) begin
        cnt++;
        if (!PWRITE || PDATA !== 64'h55 || PADDR !== 64'h20) bad++;
        if (cnt == 4) PREADY = 1'b1;
      end
      got = HREADY;
    end
    HTRANS = '0; PREADY = 1'b0; HWRITE = '0;
    checks++; if (cnt !== 4) begin failures++; $display("FAIL wr_psel_cycles got=%0d exp=4", cnt); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL wr_bus_fields bad_cycles=%0d exp=0", bad); end
    checks++; if (got !== 2'b01) begin failures++; $display("FAIL wr_hready got=%0h exp=1", got); end
    checks++; if (HRESP !== 2'b00) begin failures++; $display("FAIL wr_hresp got=%0h exp=0", HRESP); end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    logic [NM-1:0] exp_seq [4];
    logic [NM-1:0] got;
    int n;
    int rem0;
    int rem1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10; exp_seq[3] = 2'b10;
`endif
    rem0 = 2; rem1 = 2;
    HADDR[0 +: AW] = 64'h100; HADDR[AW +: AW] = 64'h200; HWRITE = '0;
    PREADY = 1'b1; PRDATA = 64'h77; HTRANS = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_hready(got, n);
      checks++; if (got !== exp_seq[t]) begin failures++; $display("FAIL b2b_grant_%0d got=%0h exp=%0h", t, got, exp_seq[t]); end
      checks++; if (n !== (t == 0 ? 2 : 3)) begin failures++; $display("FAIL b2b_latency_%0d got=%0d exp=%0d", t, n, t == 0 ? 2 : 3); end
      if (got[0]) rem0--;
      if (got[1]) rem1--;
      if (rem0 <= 0) HTRANS[0] = 1'b0;
      if (rem1 <= 0) HTRANS[1] = 1'b0;
    end
    HTRANS = '0; PREADY = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    logic [NM-1:0] got;
    int n;
    logic [AW-1:0] exp_pre;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_pre = 64'h200;
`else
    exp_pre = 64'h100;
`endif
    PREADY = 1'b1; PRDATA = 64'h99; HTRANS = 2'b01;
    wait_hready(got, n);
    HTRANS = '0;
    checks++; if (got !== 2'b01) begin failures++; $display("FAIL rst_pre_grant got=%0h exp=1", got); end
    @(negedge CLK);
    PREADY = 1'b0; HTRANS = 2'b11;
    @(negedge CLK);
    checks++; if ({PSEL, PADDR} !== {1'b1, exp_pre}) begin failures++; $display("FAIL rst_pre_paddr got=%0h/%0h exp=1/%0h", PSEL, PADDR, exp_pre); end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    #1;
    checks++; if ({PSEL, HREADY, HRESP} !== 5'b0) begin failures++; $display("FAIL rst_async_ctrl got=%0h/%0h/%0h exp=0", PSEL, HREADY, HRESP); end
    checks++; if ({HRDATA, PADDR} !== '0) begin failures++; $display("FAIL rst_async_data got=%0h/%0h exp=0/0", HRDATA, PADDR); end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checks++; if ({PSEL, PADDR, HREADY} !== {1'b1, 64'h100, 2'b00}) begin failures++; $display("FAIL rst_rearb got=%0h/%0h/%0h exp=1/100/0", PSEL, PADDR, HREADY); end
    PREADY = 1'b1;
    HTRANS = 2'b01;
    wait_hready(got, n);
    HTRANS = '0; PREADY = 1'b0;
    checks++; if (got !== 2'b01) begin failures++; $display("FAIL rst_post_grant got=%0h exp=1", got); end
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_timeout(1'b0, 64'hDEADBEEF);
    test_timeout(1'b1, 64'h0BADF00D);
    test_write_wait();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised multi-master memory arbiter and bus sequencer; successor to the two-port fetch/data memory controller. Accepts up to NUM_MASTERS concurrent requests (instruction fetch, data access, future DMA/debug ports), serialises them onto one slave bus toward ROM/RAM, supports slave wait states and a bus timeout, and raises a pipeline stall while any request is outstanding.

## Interface
Parameters:
- NUM_MASTERS, 2, number of requesting ports (2..8); index 0 is the data port.
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- TIMEOUT, 15, max wait cycles on PREADY before error termination (1..255).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- HTRANS  in  NUM_MASTERS  per-master request; held until that master's HREADY pulse.
- HADDR  in  NUM_MASTERS*ADDR_W  packed request addresses, master i at [i*ADDR_W +: ADDR_W].
- HWRITE  in  NUM_MASTERS  per-master write flag.
- HWDATA  in  NUM_MASTERS*DATA_W  packed write data.
- HREADY  out  NUM_MASTERS  one-cycle completion pulse to the served master.
- HRESP  out  NUM_MASTERS  one-cycle error pulse, coincident with HREADY, on timeout.
- HRDATA  out  DATA_W  read data, valid in the HREADY cycle, broadcast to all masters.
- stall  out  1  high while any HTRANS bit is set without its HREADY in the same cycle.
- PSEL  out  1  slave transfer active.
- PADDR  out  ADDR_W  slave address.
- PWRITE  out  1  slave write enable.
- PDATA  out  DATA_W  slave write data.
- PREADY  in  1  slave completes current transfer this cycle.
- PRDATA  in  DATA_W  slave read data.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if HTRANS nonzero, select winner, register its HADDR/HWRITE/HWDATA into PADDR/PWRITE/PDATA, PSEL<=1, grant<=winner, clear wait counter, go ACCESS; else stay.
- ACCESS: if PREADY, register PRDATA into HRDATA, PSEL<=0, go RESP. Else increment wait counter; when counter reaches TIMEOUT, PSEL<=0, set error flag, go RESP.
- RESP: HREADY[grant]=1 (HRESP[grant]=error flag) for exactly this cycle; update priority pointer; go IDLE.
- Reads and writes identical in sequencing; HRDATA undefined-but-stable after writes (holds last registered value).
- Winner selection: see Configuration. Pointer updates only in RESP.
- Master deasserting HTRANS while granted: transfer still completes; HREADY pulse still issued.
- stall = |(HTRANS & ~HREADY), combinational.

## Timing
- Reset values: PSEL=0, PADDR=0, PWRITE=0, PDATA=0, HRDATA=0, HREADY=0, HRESP=0, state IDLE, pointer 0, wait counter 0.
- Latency with PREADY tied high: request seen in cycle n -> PSEL in n+1 -> HREADY in n+2 (3-cycle occupancy incl. return to IDLE); k slave wait cycles add k.
- Back-to-back: next arbitration in IDLE cycle after RESP; one idle bus cycle between transfers.
- Timeout: PSEL high for exactly TIMEOUT cycles without PREADY -> RESP with HRESP=1, HRDATA unchanged.
- PREADY in the same cycle the counter hits TIMEOUT: PREADY wins, no error.
- PREADY while PSEL=0: ignored.
- RESET mid-transfer: immediate abort, all outputs to reset values, no HREADY pulse.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: round-robin; search starts at index pointer, pointer set to winner+1 (mod NUM_MASTERS) on completion; no master starves.
- Undefined: fixed priority, lowest index wins; pointer register removed.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ACCESS, RESP), default ADDR_W/DATA_W, TIMEOUT counter width constant (8 bits).
- One sub-module: arb_pick — combinational rotating-priority selector (request vector, start index -> one-hot winner + index), reused by both configurations with start index tied to 0 when round-robin disabled.

## Test plan
- Single read, master 1, HADDR=0x1000, PREADY high, PRDATA=0xDEADBEEF -> PSEL next cycle, HREADY[1] two cycles after request, HRDATA=0xDEADBEEF, stall high for 2 cycles.
- Masters 0 and 1 request together continuously, round-robin -> grants alternate 0,1,0,1; fixed priority -> master 0 served first, master 1 only after master 0 drops.
- Write master 0, HADDR=0x20, HWDATA=0x55, PREADY delayed 3 cycles -> PWRITE=1, PDATA=0x55 held 4 PSEL cycles, HREADY[0] after.
- PREADY held low, TIMEOUT=15 -> PSEL high exactly 15 cycles, then HREADY[g]=HRESP[g]=1 one cycle, HRDATA unchanged.
- RESET asserted during ACCESS -> PSEL, HREADY, HRDATA to 0 asynchronously; after release, pending request re-arbitrated from IDLE with pointer 0.
